fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode stage. Holds the PC and loads it from the reset vector after reset. Fetches one 16-bit instruction word per cycle, redirects on taken jumps, and folds pending interrupts into the stream. Produces the 69-bit IF/ID bundle the decode stage consumes.

## Interface
- `RESET_VEC_HI`, default 32'd0: instruction-memory address of the reset vector's high word. The low word is at `RESET_VEC_HI+1`.
- `Clk` in 1: rising-edge clock.
- `Rst` in 1: asynchronous, active-low reset.
- `ImemAddr` out 32: instruction-memory read address. The memory is combinational read.
- `ImemData` in 16: instruction word at `ImemAddr`.
- `InPort` in 16: external input port.
- `Interrupt` in 1: external interrupt request, level, synchronous to `Clk`.
- `Stall` in 1: hold PC and IF/ID. Driven by decode stall.
- `Flush` in 1: bubble IF/ID. Driven by decode flush.
- `BranchTaken` in 1: redirect PC this cycle.
- `BranchTarget` in 32: redirect address.
- `IdexMemRead` in 1: ID/EX memory-read flag.
- `IdexRdst` in 3: ID/EX destination register.
- `Out` out 69: IF/ID bundle.
  - [68:53] InPort
  - [52:21] PC of instruction
  - [20:5] instruction
  - [4] interrupt marker
  - [3] IdexMemRead
  - [2:0] IdexRdst

## Operation
- **FSM states:** VEC_HI → VEC_LO → RUN.
  - Reset enters VEC_HI.
  - VEC_HI: `ImemAddr=RESET_VEC_HI`; latch `ImemData` into PC[31:16].
  - VEC_LO: `ImemAddr=RESET_VEC_HI+1`; latch `ImemData` into PC[15:0].
  - RUN: `ImemAddr=PC`.
  - VEC_HI and VEC_LO each last one cycle regardless of Stall, Flush, BranchTaken or Interrupt.
- **Bubble definition:** Out[20:5]=16'h0000 (NOP), Out[4]=0, Out[52:21]=PC, Out[68:53]=InPort.
- Bubbles are registered during VEC_HI/VEC_LO.
- **PC update in RUN, priority order:**
  1. BranchTaken → PC ← BranchTarget.
  2. Stall → hold.
  3. Interrupt accepted → hold.
  4. Otherwise PC ← PC+1, modulo 2^32; 32'hFFFF_FFFF wraps to 0.
- **IF/ID register (Out[68:4]) update in RUN, priority order:**
  1. Flush or BranchTaken → bubble.
  2. Stall → hold all fields, including InPort.
  3. Interrupt accepted → Out[4]=1, instruction NOP, PC field = current PC, which is the return address.
  4. Otherwise load {InPort, PC, ImemData, 0}.
- **Interrupt pending latch:**
  - Set on a 0→1 edge of Interrupt. An edge detector register holds the previous level.
  - Accepted in RUN when pending, with no Stall, no Flush and no BranchTaken. Acceptance clears pending.
  - A new edge in the acceptance cycle re-sets pending.
  - Pending requests survive stalls, flushes and the vector states.
  - Only one outstanding request exists; further edges while pending are merged.
- **Load-use fields:** Out[3:0] are combinational pass-through of IdexMemRead/IdexRdst. They are not registered, so decode's hazard check sees current ID/EX.
- **Reset values** (asynchronous, while `Rst`=0):
  - state=VEC_HI, PC=0, pending=0, edge register=0.
  - Out[68:4]=0.
  - `ImemAddr`=RESET_VEC_HI.
- **Reset mid-operation:** all state is discarded immediately and the vector load restarts.

## Timing
- Fetch latency: instruction at PC appears on Out one clock after `ImemAddr=PC`.
- First real instruction reaches Out on the third rising edge after `Rst` deasserts.
- Redirect: BranchTaken in cycle n → Out holds a bubble after edge n. Target instruction is on Out after edge n+1.
- Interrupt accept: marker on Out one edge after acceptance. The next sequential fetch resumes on the edge after that, at the same PC.
- Stall: Out and PC are bit-identical across every stalled edge.

## Structure
- Shared package `processor_pkg`:
  - `NOP_INSTR` (16'h0000)
  - IF/ID field offsets (IFID_INPORT_LSB=53, IFID_PC_LSB=21, IFID_INSTR_LSB=5, IFID_INT_BIT=4)
  - `IFID_W`=69
  - fetch FSM state enum
- One sub-module, `pc_unit`: PC register, vector-load FSM and next-PC mux.
- The IF/ID register and interrupt latch live in `fetch_stage`.

## Test plan
- **Reset vector:** mem[0]=16'h0000, mem[1]=16'h0010, mem[0x10]=16'hA5A5; release Rst → Out[20:5]=0 for two edges, then Out[52:21]=32'h10 with Out[20:5]=16'hA5A5.
- **Sequential fetch and wrap:** PC=32'hFFFF_FFFF → next Out PC field = 0.
- **Stall:** assert Stall for 3 cycles at PC=0x12 → Out and `ImemAddr` are frozen; release → PC 0x13 follows.
- **Branch with simultaneous Stall:** BranchTaken=1, BranchTarget=0x40, Stall=1 → Out bubble; next edge Out PC=0x40.
- **Interrupt:** pulse Interrupt at PC=0x20 → Out[4]=1, Out[52:21]=0x20, Out[20:5]=0; next Out PC=0x20 with its real instruction.
- **Interrupt during stall, and async reset:** edge arriving while Stall=1 is taken on the first unstalled cycle. Rst low mid-RUN → Out=0 immediately, and the vector load repeats.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared definitions for the processor pipeline stages.
// IF/ID bundle layout and fetch FSM encoding.
package processor_pkg;

    localparam logic [15:0] NOP_INSTR       = 16'h0000;
    localparam int          IFID_W          = 69;
    localparam int          IFID_INPORT_LSB = 53;
    localparam int          IFID_PC_LSB     = 21;
    localparam int          IFID_INSTR_LSB  = 5;
    localparam int          IFID_INT_BIT    = 4;

    typedef enum logic [1:0] {
        FS_VEC_HI = 2'd0,
        FS_VEC_LO = 2'd1,
        FS_RUN    = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter, reset-vector load FSM and next-PC selection.
// Vector words are read from instruction memory in two cycles.
module pc_unit
    import processor_pkg::*;
#(
    parameter logic [31:0] RESET_VEC_HI = 32'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_imem_data,
    input  logic        i_stall,
    input  logic        i_branch,
    input  logic [31:0] i_target,
    input  logic        i_int_accept,
    output logic [31:0] o_pc,
    output logic [31:0] o_imem_addr,
    output logic        o_run
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        o_imem_addr  = RESET_VEC_HI;
        unique case (r_state)
            FS_VEC_HI: begin
                o_imem_addr  = RESET_VEC_HI;
                w_pc_next    = {i_imem_data, r_pc[15:0]};
                w_state_next = FS_VEC_LO;
            end
            FS_VEC_LO: begin
                o_imem_addr  = RESET_VEC_HI + 32'd1;
                w_pc_next    = {r_pc[31:16], i_imem_data};
                w_state_next = FS_RUN;
            end
            FS_RUN: begin
                o_imem_addr = r_pc;
                // An accepted interrupt replays the same PC afterwards.
                if (i_branch)
                    w_pc_next = i_target;
                else if (i_stall || i_int_accept)
                    w_pc_next = r_pc;
                else
                    w_pc_next = r_pc + 32'd1;
            end
            default: begin
                w_state_next = FS_VEC_HI;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= FS_VEC_HI;
            r_pc    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    assign o_pc  = r_pc;
    assign o_run = (r_state == FS_RUN);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and interrupt folding.
// Out[3:0] forwards ID/EX load-use info combinationally to decode.
module fetch_stage
    import processor_pkg::*;
#(
    parameter logic [31:0] RESET_VEC_HI = 32'd0
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic [31:0]       ImemAddr,
    input  logic [15:0]       ImemData,
    input  logic [15:0]       InPort,
    input  logic              Interrupt,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              BranchTaken,
    input  logic [31:0]       BranchTarget,
    input  logic              IdexMemRead,
    input  logic [2:0]        IdexRdst,
    output logic [IFID_W-1:0] Out
);

    logic [IFID_W-1:IFID_INT_BIT] r_ifid;
    logic [IFID_W-1:IFID_INT_BIT] w_ifid_next;
    logic                         r_int_prev;
    logic                         r_pend;
    logic                         w_edge;
    logic                         w_accept;
    logic                         w_run;
    logic [31:0]                  w_pc;

    assign w_edge   = Interrupt & ~r_int_prev;
    assign w_accept = w_run & r_pend & ~Stall & ~Flush & ~BranchTaken;

    pc_unit #(
        .RESET_VEC_HI (RESET_VEC_HI)
    ) u_pc (
        .i_clk        (Clk),
        .i_rst_n      (Rst),
        .i_imem_data  (ImemData),
        .i_stall      (Stall),
        .i_branch     (BranchTaken),
        .i_target     (BranchTarget),
        .i_int_accept (w_accept),
        .o_pc         (w_pc),
        .o_imem_addr  (ImemAddr),
        .o_run        (w_run)
    );

    always_comb begin
        w_ifid_next = r_ifid;
        if (!w_run || Flush || BranchTaken)
            w_ifid_next = {InPort, w_pc, NOP_INSTR, 1'b0};
        else if (Stall)
            w_ifid_next = r_ifid;
        else if (w_accept)
            w_ifid_next = {InPort, w_pc, NOP_INSTR, 1'b1};
        else
            w_ifid_next = {InPort, w_pc, ImemData, 1'b0};
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_ifid     <= '0;
            r_int_prev <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            r_ifid     <= w_ifid_next;
            r_int_prev <= Interrupt;
            // A fresh edge wins over the clear from acceptance.
            r_pend     <= w_edge | (r_pend & ~w_accept);
        end
    end

    assign Out = {r_ifid, IdexMemRead, IdexRdst};

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] VEC = 32'd0;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] ImemAddr;
    logic [15:0] ImemData;
    logic [15:0] InPort = 16'h0;
    logic        Interrupt = 1'b0;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        IdexMemRead = 1'b0;
    logic [2:0]  IdexRdst = 3'd0;
    logic [68:0] Out;

    int checks = 0;
    int errors = 0;

    logic [15:0] vec_hi = 16'h0;
    logic [15:0] vec_lo = 16'h0;
    logic [31:0] spec_a = 32'hFFFF_0000;
    logic [15:0] spec_d = 16'h0;

    int          m_phase;
    logic [31:0] m_pc;
    logic        m_pend;
    logic        m_prev;
    logic [15:0] m_in;
    logic [31:0] m_opc;
    logic [15:0] m_ins;
    logic        m_mk;

    fetch_stage #(.RESET_VEC_HI(VEC)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .ImemAddr     (ImemAddr),
        .ImemData     (ImemData),
        .InPort       (InPort),
        .Interrupt    (Interrupt),
        .Stall        (Stall),
        .Flush        (Flush),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .IdexMemRead  (IdexMemRead),
        .IdexRdst     (IdexRdst),
        .Out          (Out)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] hashw(input logic [31:0] a);
        return (a[15:0] * 16'd40503) ^ a[31:16] ^ 16'h1F2E;
    endfunction

    assign ImemData = (ImemAddr == VEC)         ? vec_hi :
                      (ImemAddr == VEC + 32'd1) ? vec_lo :
                      (ImemAddr == spec_a)      ? spec_d :
                      hashw(ImemAddr);

    function automatic logic [15:0] memf(input logic [31:0] a);
        if (a == VEC) return vec_hi;
        if (a == VEC + 32'd1) return vec_lo;
        if (a == spec_a) return spec_d;
        return hashw(a);
    endfunction

    function automatic logic [68:0] m_exp();
        return {m_in, m_opc, m_ins, m_mk, IdexMemRead, IdexRdst};
    endfunction

    function automatic logic [31:0] m_addr();
        if (m_phase == 0) return VEC;
        if (m_phase == 1) return VEC + 32'd1;
        return m_pc;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_pc = 32'h0;
        m_pend = 1'b0;
        m_prev = 1'b0;
        m_in = 16'h0;
        m_opc = 32'h0;
        m_ins = 16'h0;
        m_mk = 1'b0;
    endtask

    task automatic model_step();
        logic e;
        logic acc;
        e = Interrupt && !m_prev;
        acc = 1'b0;
        if (m_phase < 2) begin
            m_in = InPort; m_opc = m_pc; m_ins = 16'h0; m_mk = 1'b0;
            if (m_phase == 0) m_pc[31:16] = memf(VEC);
            else m_pc[15:0] = memf(VEC + 32'd1);
            m_phase++;
        end else begin
            acc = m_pend && !Stall && !Flush && !BranchTaken;
            if (Flush || BranchTaken) begin
                m_in = InPort; m_opc = m_pc; m_ins = 16'h0; m_mk = 1'b0;
            end else if (!Stall) begin
                m_in = InPort; m_opc = m_pc;
                m_ins = acc ? 16'h0 : memf(m_pc);
                m_mk = acc;
            end
            if (BranchTaken) m_pc = BranchTarget;
            else if (!Stall && !acc) m_pc = m_pc + 32'd1;
        end
        m_pend = e || (m_pend && !acc);
        m_prev = Interrupt;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic clear_inputs();
        Interrupt = 0; Stall = 0; Flush = 0; BranchTaken = 0;
        BranchTarget = 0; IdexMemRead = 0; IdexRdst = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Rst = 1'b0;
        #1;
        model_reset();
        @(negedge Clk);
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        InPort = 16'hBEEF;
        Rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (Out[68:4] !== 65'h0) begin
            errors++;
            $display("FAIL reset_out got %h want 0", Out[68:4]);
        end
        checks++;
        if (ImemAddr !== VEC) begin
            errors++;
            $display("FAIL reset_addr got %h want %h", ImemAddr, VEC);
        end
        IdexMemRead = 1'b1; IdexRdst = 3'd5;
        #1;
        checks++;
        if (Out[3:0] !== 4'hD) begin
            errors++;
            $display("FAIL loaduse_pass got %h want d", Out[3:0]);
        end
    endtask

    task automatic test_reset_vector();
        vec_hi = 16'h0000; vec_lo = 16'h0010;
        spec_a = 32'h10; spec_d = 16'hA5A5;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (Out[20:5] !== 16'h0 || Out !== m_exp()) begin
                errors++;
                $display("FAIL vec_bubble%0d got %h want %h", i, Out, m_exp());
            end
        end
        tick();
        checks++;
        if (Out[52:21] !== 32'h10 || Out[20:5] !== 16'hA5A5) begin
            errors++;
            $display("FAIL vec_first got pc %h ins %h want 10 a5a5",
                     Out[52:21], Out[20:5]);
        end
    endtask

    task automatic test_wrap();
        vec_hi = 16'hFFFF; vec_lo = 16'hFFFF;
        do_reset();
        repeat (3) tick();
        checks++;
        if (Out[52:21] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_last got %h want ffffffff", Out[52:21]);
        end
        tick();
        checks++;
        if (Out[52:21] !== 32'h0 || Out !== m_exp()) begin
            errors++;
            $display("FAIL wrap_zero got %h want %h", Out, m_exp());
        end
    endtask

    task automatic test_stall();
        logic [68:0] o;
        logic [31:0] a;
        vec_hi = 16'h0; vec_lo = 16'h0012;
        do_reset();
        repeat (3) tick();
        o = Out;
        a = ImemAddr;
        checks++;
        if (o[52:21] !== 32'h12) begin
            errors++;
            $display("FAIL stall_setup got %h want 12", o[52:21]);
        end
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            InPort = 16'(i + 7);
            tick();
            checks++;
            if (Out !== o || ImemAddr !== a) begin
                errors++;
                $display("FAIL stall_hold%0d got %h/%h want %h/%h",
                         i, Out, ImemAddr, o, a);
            end
        end
        Stall = 1'b0;
        tick();
        checks++;
        if (Out[52:21] !== 32'h13 || Out !== m_exp()) begin
            errors++;
            $display("FAIL stall_release got %h want %h", Out, m_exp());
        end
    endtask

    task automatic test_branch_stall();
        BranchTaken = 1'b1; BranchTarget = 32'h40; Stall = 1'b1;
        tick();
        checks++;
        if (Out[20:4] !== 17'h0 || Out !== m_exp()) begin
            errors++;
            $display("FAIL br_bubble got %h want %h", Out, m_exp());
        end
        BranchTaken = 1'b0; Stall = 1'b0;
        tick();
        checks++;
        if (Out[52:21] !== 32'h40 || Out[20:5] !== memf(32'h40)) begin
            errors++;
            $display("FAIL br_target got pc %h ins %h want 40 %h",
                     Out[52:21], Out[20:5], memf(32'h40));
        end
    endtask

    task automatic test_interrupt();
        vec_hi = 16'h0; vec_lo = 16'h0020;
        do_reset();
        tick();
        Interrupt = 1'b1;
        tick();
        Interrupt = 1'b0;
        tick();
        checks++;
        if (Out[4] !== 1'b1 || Out[52:21] !== 32'h20 || Out[20:5] !== 16'h0) begin
            errors++;
            $display("FAIL int_marker got %h want mk=1 pc=20 ins=0", Out[68:4]);
        end
        tick();
        checks++;
        if (Out[4] !== 1'b0 || Out[52:21] !== 32'h20 || Out[20:5] !== memf(32'h20)) begin
            errors++;
            $display("FAIL int_resume got %h want %h", Out, m_exp());
        end
    endtask

    task automatic test_int_stall();
        Stall = 1'b1; Interrupt = 1'b1;
        tick();
        Interrupt = 1'b0;
        tick();
        checks++;
        if (Out[4] !== 1'b0 || Out !== m_exp()) begin
            errors++;
            $display("FAIL intst_hold got %h want %h", Out, m_exp());
        end
        Stall = 1'b0;
        tick();
        checks++;
        if (Out[4] !== 1'b1 || Out[52:21] !== 32'h21) begin
            errors++;
            $display("FAIL intst_accept got mk %b pc %h want 1 21", Out[4], Out[52:21]);
        end
        tick();
        checks++;
        if (Out[52:21] !== 32'h21 || Out[4] !== 1'b0 || Out !== m_exp()) begin
            errors++;
            $display("FAIL intst_resume got %h want %h", Out, m_exp());
        end
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        #2;
        Rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (Out[68:4] !== 65'h0 || ImemAddr !== VEC) begin
            errors++;
            $display("FAIL areset got %h/%h want 0/%h", Out[68:4], ImemAddr, VEC);
        end
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (Out !== m_exp() || ImemAddr !== m_addr()) begin
                errors++;
                $display("FAIL areset_vec%0d got %h/%h want %h/%h",
                         i, Out, ImemAddr, m_exp(), m_addr());
            end
        end
        checks++;
        if (Out[52:21] !== 32'h20) begin
            errors++;
            $display("FAIL areset_pc got %h want 20", Out[52:21]);
        end
    endtask

    task automatic test_random();
        vec_hi = 16'h1234; vec_lo = 16'h5678;
        spec_a = 32'hFFFF_0000;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            InPort = 16'($urandom);
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            BranchTaken = ($urandom_range(0, 9) == 0);
            BranchTarget = $urandom;
            if ($urandom_range(0, 4) == 0) Interrupt = ~Interrupt;
            IdexMemRead = 1'($urandom);
            IdexRdst = 3'($urandom);
            tick();
            checks++;
            if (Out !== m_exp() || ImemAddr !== m_addr()) begin
                errors++;
                $display("FAIL rand%0d got %h/%h want %h/%h",
                         i, Out, ImemAddr, m_exp(), m_addr());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_vector();
        test_wrap();
        test_stall();
        test_branch_stall();
        test_interrupt();
        test_int_stall();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
